// File: rtl/receiver_pkg.sv
// Shared link definitions for the Manchester serial receiver: magic patterns,
// framing state encodings and status word bit positions (common with the
// transmitter side of the link), plus a helper that packs the status word.
package receiver_pkg;

  localparam logic [31:0] LINK_SYNC_MAGIC  = 32'h0000_96C3;
  localparam logic [31:0] LINK_START_MAGIC = 32'h0000_EA57;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SIZE = 2'd1,
    ST_DATA = 2'd2
  } rx_state_e;

  localparam int unsigned STAT_LOCKED    = 15;
  localparam int unsigned STAT_IN_FRAME  = 14;
  localparam int unsigned STAT_STATE_LSB = 8;
  localparam int unsigned STAT_BAD_STATE = 5;
  localparam int unsigned STAT_CARRIER   = 4;
  localparam int unsigned STAT_SIZE_ERR  = 3;
  localparam int unsigned STAT_TIMEOUT   = 2;

  function automatic logic [15:0] build_status(input logic      locked,
                                               input rx_state_e st,
                                               input logic      bad_state,
                                               input logic      carrier_lost,
                                               input logic      size_error,
                                               input logic      timeout);
    logic [15:0] s;
    s                         = '0;
    s[STAT_LOCKED]            = locked;
    s[STAT_IN_FRAME]          = (st != ST_HUNT);
    s[STAT_STATE_LSB +: 4]    = {2'b00, st};
    s[STAT_BAD_STATE]         = bad_state;
    s[STAT_CARRIER]           = carrier_lost;
    s[STAT_SIZE_ERR]          = size_error;
    s[STAT_TIMEOUT]           = timeout;
    return s;
  endfunction

endpackage

// File: rtl/receiver_manchester_decoder.sv
// Manchester bit recovery for the receiver.
// Synchronizes the asynchronous line (2 FFs + 1 history FF), detects edges,
// counts cycles since the last accepted (mid-bit) edge and emits one bit strobe
// per accepted edge. Edges arriving earlier than 3/4 of a bit period after the
// last accepted edge are bit-boundary edges and are ignored.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   rx_i            : raw serial line
//   bit_o           : recovered bit (1 = falling mid-bit edge), valid with bit_valid_o
//   bit_valid_o     : one-cycle bit strobe, 3 cycles after the line transition
//   carrier_lost_o  : high while the edge counter is saturated (no mid-bit edge)
module receiver_manchester_decoder #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic bit_o,
  output logic bit_valid_o,
  output logic carrier_lost_o
);

  localparam int unsigned CW = $clog2(2 * OVERSAMPLE + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(2 * OVERSAMPLE);
  localparam logic [CW-1:0] CNT_THR = CW'(3 * OVERSAMPLE / 4);

  logic          rx_meta_q, rx_sync_q, rx_hist_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_q, bit_valid_q;
  logic          rx_edge, accept;

  always_comb begin
    rx_edge = rx_sync_q ^ rx_hist_q;
    // A saturated counter is always >= threshold, so this also covers the
    // first edge after a quiet line.
    accept  = rx_edge && (cnt_q >= CNT_THR);
    if (accept) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = CNT_SAT;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_hist_q   <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_hist_q   <= rx_sync_q;
      cnt_q       <= cnt_d;
      bit_valid_q <= accept;
      // Old level 1 means a falling edge, which carries a 1.
      if (accept) begin
        bit_q <= rx_hist_q;
      end
    end
  end

  assign bit_o          = bit_q;
  assign bit_valid_o    = bit_valid_q;
  assign carrier_lost_o = (cnt_q == CNT_SAT);

endmodule

// File: rtl/receiver.sv
// Receive end of the Manchester serial link.
// Locks on SYNC_MAGIC, frames on START_MAGIC, reads a 16-bit little-endian
// size and streams the payload bytes out with frame strobes and status.
// Optional feature macro: RECEIVER_TIMEOUT_EN (bit-period watchdog in SIZE/DATA).
// Ports:
//   i_clk, i_rst_n     : clock (OVERSAMPLE x bit rate), synchronous active-low reset
//   i_rx               : asynchronous serial line
//   i_clear_errors     : pulse, clears sticky status bits
//   o_data/o_data_valid: payload byte and its strobe
//   o_frame_start      : strobe on start-magic match
//   o_frame_done       : strobe with the last payload byte
//   o_frame_size       : size field of the current/last frame
//   o_frames_count     : completed frames modulo 256
//   o_locked           : link locked
//   o_status           : {locked, in_frame, 2'b0, state[3:0], 2'b0, bad_state,
//                         carrier_lost, size_error, timeout, 2'b0}
module receiver
  import receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE     = 8,
  parameter logic [31:0] SYNC_MAGIC     = LINK_SYNC_MAGIC,
  parameter logic [31:0] START_MAGIC    = LINK_START_MAGIC,
  parameter logic [15:0] MAX_FRAME_SIZE = 16'd4096,
  parameter int unsigned TIMEOUT_BITS   = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic        i_clear_errors,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic [15:0] o_frame_size,
  output logic [7:0]  o_frames_count,
  output logic        o_locked,
  output logic [15:0] o_status
);

  logic dec_bit, dec_valid, dec_carrier_lost;

  receiver_manchester_decoder #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_dec (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .rx_i          (i_rx),
    .bit_o         (dec_bit),
    .bit_valid_o   (dec_valid),
    .carrier_lost_o(dec_carrier_lost)
  );

  rx_state_e   state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic        strb_q;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [15:0] bytecnt_q, bytecnt_d;
  logic [15:0] frame_size_q, frame_size_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frames_count_q, frames_count_d;
  logic        locked_q, locked_d;
  logic        bad_q, bad_d, carr_q, carr_d, size_q, size_d;
  logic        err_bad, err_carr, err_size;
  logic        timeout_flag;

`ifdef RECEIVER_TIMEOUT_EN
  logic [15:0] wd_cyc_q, wd_cyc_d, wd_bits_q, wd_bits_d;
  logic        tmo_q, tmo_d, err_tmo;
  assign timeout_flag = tmo_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    bitcnt_d       = bitcnt_q;
    bytecnt_d      = bytecnt_q;
    frame_size_d   = frame_size_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    frame_start_d  = 1'b0;
    frame_done_d   = 1'b0;
    frames_count_d = frames_count_q;
    locked_d       = locked_q;
    err_bad        = 1'b0;
    err_carr       = 1'b0;
    err_size       = 1'b0;

    if (dec_valid) begin
      sr_d = {dec_bit, sr_q[31:1]};
    end

`ifdef RECEIVER_TIMEOUT_EN
    err_tmo   = 1'b0;
    wd_cyc_d  = wd_cyc_q;
    wd_bits_d = wd_bits_q;
    if (state_q == ST_HUNT || strb_q) begin
      wd_cyc_d  = '0;
      wd_bits_d = '0;
    end else if (wd_cyc_q == 16'(OVERSAMPLE - 1)) begin
      wd_cyc_d  = '0;
      wd_bits_d = wd_bits_q + 16'd1;
    end else begin
      wd_cyc_d  = wd_cyc_q + 16'd1;
    end
`endif

    if (dec_carrier_lost) begin
      locked_d = 1'b0;
      state_d  = ST_HUNT;
      err_carr = (state_q != ST_HUNT);
    end else begin
      // Fields are decoded from sr_q the cycle after each strobe: after n
      // shifts the first of those n bits sits at sr_q[32-n].
      case (state_q)
        ST_HUNT: begin
          if (strb_q) begin
            if (sr_q == SYNC_MAGIC) begin
              locked_d = 1'b1;
            end else if (sr_q == START_MAGIC && locked_q) begin
              frame_start_d = 1'b1;
              bitcnt_d      = '0;
              state_d       = ST_SIZE;
            end
          end
        end
        ST_SIZE: begin
          if (strb_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd15) begin
              frame_size_d = sr_q[31:16];
              if (sr_q[31:16] == 16'd0 || sr_q[31:16] > MAX_FRAME_SIZE) begin
                err_size = 1'b1;
                state_d  = ST_HUNT;
              end else begin
                bitcnt_d  = '0;
                bytecnt_d = '0;
                state_d   = ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (strb_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d     = '0;
              data_d       = sr_q[31:24];
              data_valid_d = 1'b1;
              bytecnt_d    = bytecnt_q + 16'd1;
              if (bytecnt_q + 16'd1 == frame_size_q) begin
                frame_done_d   = 1'b1;
                frames_count_d = frames_count_q + 8'd1;
                state_d        = ST_HUNT;
              end
            end
          end
        end
        default: begin
          err_bad = 1'b1;
          state_d = ST_HUNT;
        end
      endcase

`ifdef RECEIVER_TIMEOUT_EN
      if (state_q != ST_HUNT && !strb_q && wd_bits_q == 16'(TIMEOUT_BITS)) begin
        err_tmo      = 1'b1;
        state_d      = ST_HUNT;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
      end
`endif
    end

    bad_d  = (bad_q  & ~i_clear_errors) | err_bad;
    carr_d = (carr_q & ~i_clear_errors) | err_carr;
    size_d = (size_q & ~i_clear_errors) | err_size;
`ifdef RECEIVER_TIMEOUT_EN
    tmo_d  = (tmo_q  & ~i_clear_errors) | err_tmo;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= ST_HUNT;
      sr_q           <= '0;
      strb_q         <= 1'b0;
      bitcnt_q       <= '0;
      bytecnt_q      <= '0;
      frame_size_q   <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      frames_count_q <= '0;
      locked_q       <= 1'b0;
      bad_q          <= 1'b0;
      carr_q         <= 1'b0;
      size_q         <= 1'b0;
`ifdef RECEIVER_TIMEOUT_EN
      wd_cyc_q       <= '0;
      wd_bits_q      <= '0;
      tmo_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      strb_q         <= dec_valid;
      bitcnt_q       <= bitcnt_d;
      bytecnt_q      <= bytecnt_d;
      frame_size_q   <= frame_size_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      frame_start_q  <= frame_start_d;
      frame_done_q   <= frame_done_d;
      frames_count_q <= frames_count_d;
      locked_q       <= locked_d;
      bad_q          <= bad_d;
      carr_q         <= carr_d;
      size_q         <= size_d;
`ifdef RECEIVER_TIMEOUT_EN
      wd_cyc_q       <= wd_cyc_d;
      wd_bits_q      <= wd_bits_d;
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign o_data         = data_q;
  assign o_data_valid   = data_valid_q;
  assign o_frame_start  = frame_start_q;
  assign o_frame_done   = frame_done_q;
  assign o_frame_size   = frame_size_q;
  assign o_frames_count = frames_count_q;
  assign o_locked       = locked_q;
  assign o_status       = build_status(locked_q, state_q, bad_q, carr_q, size_q, timeout_flag);

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: lock, framing, size error, carrier loss,
// jittered line with frame-counter wrap, and reset in the middle of a frame.
// OVERSAMPLE is 6 here so the 255-frame wrap sequence stays short; edge
// jitter is an extra 0/1 cycle delay per edge (edge-to-edge intervals vary by
// +-1 cycle).
module tb_receiver;

  localparam int unsigned OS    = 6;
  localparam int unsigned HALF  = OS / 2;
  localparam logic [31:0] SYNC  = 32'h0000_96C3;
  localparam logic [31:0] START = 32'h0000_EA57;

  logic        clk;
  logic        i_rst_n, i_rx, i_clear_errors;
  logic [7:0]  o_data;
  logic        o_data_valid, o_frame_start, o_frame_done, o_locked;
  logic [15:0] o_frame_size, o_status;
  logic [7:0]  o_frames_count;

  receiver #(
    .OVERSAMPLE(OS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_rx          (i_rx),
    .i_clear_errors(i_clear_errors),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_frame_start (o_frame_start),
    .o_frame_done  (o_frame_done),
    .o_frame_size  (o_frame_size),
    .o_frames_count(o_frames_count),
    .o_locked      (o_locked),
    .o_status      (o_status)
  );

  int          checks = 0;
  int          failures = 0;
  int          starts = 0;
  int          dones = 0;
  int          done_no_valid = 0;
  logic [7:0]  rxq[$];
  bit          jit = 0;
  int unsigned off = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  always @(negedge clk) begin
    if (o_data_valid) rxq.push_back(o_data);
    if (o_frame_start) starts++;
    if (o_frame_done) begin
      dones++;
      if (!o_data_valid) done_no_valid++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One half-bit: set the level at the edge point, hold until the next edge point.
  task automatic drive_half(input logic lvl);
    int unsigned n;
    n = jit ? $urandom_range(1, 0) : 0;
    i_rx = lvl;
    repeat (HALF + n - off) @(negedge clk);
    off = n;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      drive_half(w[i]);
      drive_half(~w[i]);
    end
  endtask

  task automatic idle_static(input int cycles);
    i_rx = 1'b0;
    off  = 0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    i_clear_errors = 1'b1;
    @(negedge clk);
    i_clear_errors = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int          snap;
    i_rx = 1'b0;
    i_rst_n = 1'b0;
    i_clear_errors = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", o_data, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_fstart", o_frame_start, 0);
    check("rst_fdone", o_frame_done, 0);
    check("rst_fsize", o_frame_size, 0);
    check("rst_count", o_frames_count, 0);
    check("rst_locked", o_locked, 0);
    check("rst_status", o_status, 0);
    i_rst_n = 1'b1;
    idle_static(20);

    // 1: lock acquisition
    send_word(32'h0, 8);
    send_word(SYNC, 31);
    check("t1_not_locked_31bits", o_locked, 0);
    w = SYNC;
    drive_half(w[31]);
    drive_half(~w[31]);
    send_word(32'h0, 2);
    check("t1_locked", o_locked, 1);
    check("t1_status", o_status, 16'h8000);

    // 2: normal 3-byte frame
    send_word(START, 32);
    send_word(32'h0003, 16);
    send_word(32'hA5, 8);
    send_word(32'h3C, 8);
    send_word(32'hFF, 8);
    send_word(32'h0, 2);
    check("t2_starts", starts, 1);
    check("t2_nbytes", rxq.size(), 3);
    check("t2_byte0", rxq[0], 8'hA5);
    check("t2_byte1", rxq[1], 8'h3C);
    check("t2_byte2", rxq[2], 8'hFF);
    check("t2_dones", dones, 1);
    check("t2_done_with_valid", done_no_valid, 0);
    check("t2_count", o_frames_count, 1);
    check("t2_fsize", o_frame_size, 3);
    check("t2_status", o_status, 16'h8000);

    // 3: size zero -> size_error, then clear
    send_word(START, 32);
    send_word(32'h0, 16);
    send_word(32'h0, 2);
    check("t3_status", o_status, 16'h8008);
    check("t3_fsize", o_frame_size, 0);
    check("t3_nbytes", rxq.size(), 3);
    check("t3_count", o_frames_count, 1);
    check("t3_starts", starts, 2);
    fork
      send_word(32'h0, 4);
      pulse_clear();
    join
    check("t3_status_cleared", o_status, 16'h8000);

    // 4: carrier loss mid-frame
    send_word(START, 32);
    send_word(32'h0002, 16);
    send_word(32'h11, 8);
    idle_static(4 * OS);
    check("t4_locked", o_locked, 0);
    check("t4_status", o_status, 16'h0010);
    check("t4_dones", dones, 1);
    check("t4_count", o_frames_count, 1);
    check("t4_nbytes", rxq.size(), 4);
    check("t4_byte", rxq[3], 8'h11);
    pulse_clear();
    check("t4_status_cleared", o_status, 16'h0000);

    // relock
    idle_static(4 * OS);
    send_word(32'h0, 8);
    send_word(SYNC, 32);
    send_word(32'h0, 2);
    check("t5_relocked", o_locked, 1);

    // 5: jittered line, frame counter wraps
    jit = 1;
    for (int f = 0; f < 254; f++) begin
      send_word(START, 32);
      send_word(32'h0001, 16);
      send_word({24'h0, 8'(f) ^ 8'h5A}, 8);
    end
    send_word(32'h0, 2);
    check("t5_count_255", o_frames_count, 8'd255);
    send_word(START, 32);
    send_word(32'h0001, 16);
    send_word({24'h0, 8'(254) ^ 8'h5A}, 8);
    send_word(32'h0, 2);
    jit = 0;
    check("t5_count_wrap", o_frames_count, 8'd0);
    check("t5_dones", dones, 256);
    check("t5_done_with_valid", done_no_valid, 0);
    check("t5_nbytes", rxq.size(), 4 + 255);
    for (int i = 0; i < 255; i++) begin
      check($sformatf("t5_byte%0d", i), rxq[4 + i], 8'(i) ^ 8'h5A);
    end
    check("t5_status", o_status, 16'h8000);

    // 6: reset mid-DATA, then start magic without sync
    send_word(START, 32);
    send_word(32'h0004, 16);
    send_word(32'h77, 8);
    send_word(32'h0, 3);
    check("t6_byte_before_rst", rxq[rxq.size() - 1], 8'h77);
    check("t6_status_data", o_status, 16'hC200);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_data", o_data, 0);
    check("t6_rst_valid", o_data_valid, 0);
    check("t6_rst_fsize", o_frame_size, 0);
    check("t6_rst_count", o_frames_count, 0);
    check("t6_rst_locked", o_locked, 0);
    check("t6_rst_status", o_status, 0);
    i_rst_n = 1'b1;
    snap = starts;
    idle_static(4 * OS);
    send_word(32'h0, 8);
    send_word(START, 32);
    send_word(32'h0, 24);
    check("t6_start_unlocked_ignored", starts, snap);
    check("t6_still_unlocked", o_locked, 0);
    check("t6_status_hunt", o_status, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
